// File: rtl/housekeeping_spi_wb_bridge.sv
// Bridges housekeeping SPI byte accesses onto single-beat Wishbone transfers.
// Latency: write push to cyc rise 1 cycle when idle; reads complete behind posted writes.
// Backpressure: writes post into a FIFO (dropped + fifo_ovf when full); reads wait for ack.
// Optional macro HKSPI_BUS_TIMEOUT_EN: abort bus cycles that see no ack within WB_TIMEOUT cycles.
module housekeeping_spi_wb_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h2610_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          WB_TIMEOUT = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        spi_csb,
  input  logic        spi_wrstb,
  input  logic        spi_rdstb,
  input  logic [7:0]  spi_addr,
  input  logic [7:0]  spi_wdata,
  output logic [7:0]  spi_rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy,
  output logic        fifo_ovf,
  output logic        timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS} state_t;

  logic csb_meta_q, csb_sync_q, csb_prev_q;
  logic wr_meta_q, wr_sync_q, wr_prev_q;
  logic rd_meta_q, rd_sync_q, rd_prev_q;

  logic [15:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  state_t      state_q;
  logic        cyc_q, we_q, ovf_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;
  logic [7:0]  rdata_q;
  logic        rd_pend_q, last_vld_q;
  logic [7:0]  rd_addr_q, cur_addr_q, samp_q, last_addr_q;

  logic wr_rise, rd_rise, csb_rise, fifo_full, push, pop;
  logic tmo_hit, bus_done, samp_hit, rd_launch;
  logic [15:0] head;

  function automatic logic [31:0] map_adr(input logic [7:0] a);
    return BASE_ADDR + {24'b0, a[7:2], 2'b00};
  endfunction

  function automatic logic [7:0] lane_of(input logic [31:0] d, input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  assign wr_rise   = wr_sync_q & ~wr_prev_q;
  assign rd_rise   = rd_sync_q & ~rd_prev_q;
  assign csb_rise  = csb_sync_q & ~csb_prev_q;
  assign fifo_full = (cnt_q == FULL_CNT);
  assign push      = wr_rise & ~fifo_full;
  assign bus_done  = wb_ack_i | tmo_hit;
  assign pop       = (state_q == WR_BUS) & bus_done;
  assign head      = fifo_mem_q[rd_ptr_q];

  // A stable new address under rdstb is a streaming read; suppress while one is queued or in flight.
  assign samp_hit  = rd_sync_q & rd_prev_q & (spi_addr == samp_q) &
                     ~(last_vld_q & (spi_addr == last_addr_q)) &
                     ~rd_pend_q & (state_q != RD_BUS);
  assign rd_launch = rd_rise | samp_hit;

  // FIFO occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Two-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      {csb_meta_q, csb_sync_q, csb_prev_q} <= 3'b111;
      {wr_meta_q, wr_sync_q, wr_prev_q}    <= 3'b000;
      {rd_meta_q, rd_sync_q, rd_prev_q}    <= 3'b000;
    end else begin
      {csb_meta_q, csb_sync_q, csb_prev_q} <= {spi_csb, csb_meta_q, csb_sync_q};
      {wr_meta_q, wr_sync_q, wr_prev_q}    <= {spi_wrstb, wr_meta_q, wr_sync_q};
      {rd_meta_q, rd_sync_q, rd_prev_q}    <= {spi_rdstb, rd_meta_q, rd_sync_q};
    end
  end

  // Posted-write storage; the SPI stage holds addr/data stable while wrstb is high.
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {spi_addr, spi_wdata};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Bus FSM with registered Wishbone outputs, read queueing and sticky overflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0;
      adr_q       <= 32'b0;
      dat_q       <= 32'b0;
      rdata_q     <= 8'hFF;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= 8'b0;
      cur_addr_q  <= 8'b0;
      samp_q      <= 8'b0;
      last_addr_q <= 8'b0;
      last_vld_q  <= 1'b0;
    end else begin
      if (wr_rise && fifo_full) ovf_q <= 1'b1;
      if (rd_sync_q) samp_q <= spi_addr;
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_q <= WR_BUS;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= map_adr(head[15:8]);
            sel_q   <= 4'b0001 << head[9:8];
            dat_q   <= {4{head[7:0]}};
          end else if (rd_pend_q) begin
            state_q    <= RD_BUS;
            cyc_q      <= 1'b1;
            we_q       <= 1'b0;
            adr_q      <= map_adr(rd_addr_q);
            sel_q      <= 4'b0001 << rd_addr_q[1:0];
            cur_addr_q <= rd_addr_q;
            rd_pend_q  <= 1'b0;
          end
        end
        WR_BUS: begin
          if (bus_done) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        RD_BUS: begin
          if (bus_done) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            rdata_q     <= wb_ack_i ? lane_of(wb_dat_i, cur_addr_q[1:0]) : 8'hFF;
            // A timed-out address is also recorded so it is not retried until the address moves.
            last_addr_q <= cur_addr_q;
            last_vld_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (rd_launch) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= spi_addr;
      end
      if (csb_rise) begin
        rd_pend_q  <= 1'b0;
        last_vld_q <= 1'b0;
      end
    end
  end

`ifdef HKSPI_BUS_TIMEOUT_EN
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_err_q;

  assign tmo_hit     = (state_q != IDLE) && !wb_ack_i && (tmo_cnt_q == TW'(WB_TIMEOUT - 1));
  assign timeout_err = tmo_err_q;

  // Counts cycles spent waiting for ack; restarts every time the FSM returns to IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q == IDLE) tmo_cnt_q <= '0;
    else                             tmo_cnt_q <= tmo_cnt_q + TW'(1);
    if (wb_rst_i)     tmo_err_q <= 1'b0;
    else if (tmo_hit) tmo_err_q <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (WB_TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign spi_rdata = rdata_q;
  assign fifo_ovf  = ovf_q;
  assign busy      = (cnt_q != '0) || (state_q != IDLE);

endmodule
